// File: rtl/alu_core.sv
// ============================================================================
// alu_core : execute-stage ALU; single-cycle logic/arith ops plus iterative
//            shift-add multiply and restoring divide with start/busy/done.
//            Optional macro ALU_SIGNED_MULDIV_EN selects signed mult/div.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;   // product high / partial remainder
  logic [WIDTH-1:0] lo;    // multiplier / dividend -> quotient
  logic [WIDTH-1:0] opnd;  // multiplicand / divisor

  logic accept, is_mul, is_div, b_zero, last;

  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign is_mul = (alu_ctrl == 4'd7);
  assign is_div = (alu_ctrl == 4'd8);
  assign b_zero = (b == '0);
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  assign zero = (result == '0);
  assign busy = (state == S_MUL) || (state == S_DIV);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (is_mul)                state_n = S_MUL;
          else if (is_div && !b_zero) state_n = S_DIV;
          else                       state_n = S_DONE;
        end else if (state == S_DONE) begin
          state_n = S_IDLE;
        end
      end
      S_MUL, S_DIV: if (last) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  // single-cycle ops
  logic [WIDTH-1:0] simple_res;
  logic             lt_s, gt_s, eq;

  always_comb begin
    lt_s       = $signed(a) < $signed(b);
    gt_s       = $signed(a) > $signed(b);
    eq         = (a == b);
    simple_res = '0;
    case (alu_ctrl)
      4'd0:    simple_res = a & b;
      4'd1:    simple_res = a | b;
      4'd2:    simple_res = a + b;
      4'd3:    simple_res = a - b;
      4'd4:    simple_res = {{(WIDTH-1){1'b0}}, lt_s};
      4'd5:    simple_res = {{(WIDTH-1){1'b0}}, gt_s};
      4'd6:    simple_res = ~a;
      4'd9:    simple_res = a << shamt;
      4'd10:   simple_res = a >> shamt;
      4'd11:   simple_res = {{(WIDTH-1){1'b0}}, !gt_s};
      4'd12:   simple_res = {{(WIDTH-1){1'b0}}, !lt_s};
      4'd13:   simple_res = {{(WIDTH-1){1'b0}}, eq};
      4'd14:   simple_res = {{(WIDTH-1){1'b0}}, !eq};
      default: simple_res = '0;
    endcase
  end

  // operand magnitudes loaded into the iterative datapath
  logic [WIDTH-1:0] mag_a, mag_b;
`ifdef ALU_SIGNED_MULDIV_EN
  logic neg_p, neg_r;
  assign mag_a = a[WIDTH-1] ? -a : a;
  assign mag_b = b[WIDTH-1] ? -b : b;
`else
  assign mag_a = a;
  assign mag_b = b;
`endif

  // one shift-add multiply step
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_acc_n, mul_lo_n;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign mul_sum   = {1'b0, acc} + {1'b0, (lo[0] ? opnd : '0)};
  assign mul_acc_n = mul_sum[WIDTH:1];
  assign mul_lo_n  = {mul_sum[0], lo[WIDTH-1:1]};
  assign prod      = {mul_acc_n, mul_lo_n};

  // one restoring divide step
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff, div_acc_n, div_lo_n, quo_fix, rem_fix;
  logic             div_ok;

  assign div_shift = {acc, lo[WIDTH-1]};
  assign div_ok    = (div_shift >= {1'b0, opnd});
  // when the subtract succeeds the difference is below the divisor, so WIDTH bits suffice
  assign div_diff  = div_shift[WIDTH-1:0] - opnd;
  assign div_acc_n = div_ok ? div_diff : div_shift[WIDTH-1:0];
  assign div_lo_n  = {lo[WIDTH-2:0], div_ok};

`ifdef ALU_SIGNED_MULDIV_EN
  assign prod_fix = neg_p ? -prod : prod;
  assign quo_fix  = neg_p ? -div_lo_n : div_lo_n;
  assign rem_fix  = neg_r ? -div_acc_n : div_acc_n;
`else
  assign prod_fix = prod;
  assign quo_fix  = div_lo_n;
  assign rem_fix  = div_acc_n;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      lo          <= '0;
      opnd        <= '0;
      result      <= '0;
      hi          <= '0;
      div_by_zero <= 1'b0;
`ifdef ALU_SIGNED_MULDIV_EN
      neg_p       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else if (accept) begin
      cnt <= '0;
`ifdef ALU_SIGNED_MULDIV_EN
      neg_p <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r <= a[WIDTH-1];
`endif
      if (is_mul) begin
        acc  <= '0;
        lo   <= mag_b;
        opnd <= mag_a;
      end else if (is_div && !b_zero) begin
        acc  <= '0;
        lo   <= mag_a;
        opnd <= mag_b;
      end else if (is_div) begin
        result      <= '1;
        hi          <= a;
        div_by_zero <= 1'b1;
      end else begin
        result      <= simple_res;
        hi          <= '0;
        div_by_zero <= 1'b0;
      end
    end else if (state == S_MUL) begin
      acc <= mul_acc_n;
      lo  <= mul_lo_n;
      cnt <= cnt + 1'b1;
      if (last) begin
        {hi, result} <= prod_fix;
        div_by_zero  <= 1'b0;
      end
    end else if (state == S_DIV) begin
      acc <= div_acc_n;
      lo  <= div_lo_n;
      cnt <= cnt + 1'b1;
      if (last) begin
        result      <= quo_fix;
        hi          <= rem_fix;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_core.sv
// ============================================================================
// tb_alu_core : self-checking bench for alu_core (table vectors, hand-written
//               corner sequences, random ops against a behavioural model).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_core;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  alu_ctrl;
  logic [31:0] a, b, result, hi;
  logic [4:0]  shamt;
  logic        zero, busy, done, div_by_zero;

  int total = 0;
  int bad   = 0;

  alu_core #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_ctrl(alu_ctrl),
    .a(a), .b(b), .shamt(shamt), .result(result), .hi(hi),
    .zero(zero), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic [31:0] r, h;
    logic        d;
  } vec_t;

  localparam int NVEC = 23;
  vec_t tbl [NVEC];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // behavioural reference: plain arithmetic on the op-code table
  function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                input logic [4:0] s, output logic [31:0] r, output logic [31:0] h,
                                output logic d);
    longint sx, sy, q, m;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    r = '0; h = '0; d = 1'b0;
    case (op)
      4'd0:  r = x & y;
      4'd1:  r = x | y;
      4'd2:  r = x + y;
      4'd3:  r = x - y;
      4'd4:  r = (sx <  sy) ? 32'd1 : 32'd0;
      4'd5:  r = (sx >  sy) ? 32'd1 : 32'd0;
      4'd6:  r = ~x;
      4'd7: begin
`ifdef ALU_SIGNED_MULDIV_EN
        p = sx * sy;
`else
        p = {32'd0, x} * {32'd0, y};
`endif
        r = p[31:0];
        h = p[63:32];
      end
      4'd8: begin
        if (y == 32'd0) begin
          r = '1; h = x; d = 1'b1;
        end else begin
`ifdef ALU_SIGNED_MULDIV_EN
          q = sx / sy;
          m = sx % sy;
`else
          q = longint'({32'd0, x}) / longint'({32'd0, y});
          m = longint'({32'd0, x}) % longint'({32'd0, y});
`endif
          r = q[31:0];
          h = m[31:0];
        end
      end
      4'd9:  r = x << s;
      4'd10: r = x >> s;
      4'd11: r = (sx <= sy) ? 32'd1 : 32'd0;
      4'd12: r = (sx >= sy) ? 32'd1 : 32'd0;
      4'd13: r = (x == y) ? 32'd1 : 32'd0;
      4'd14: r = (x != y) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
  endfunction

  // issue one op, then scramble the operand inputs to prove they were captured
  task automatic do_op(input string nm, input logic [3:0] op, input logic [31:0] ia,
                       input logic [31:0] ib, input logic [4:0] sh,
                       input logic [31:0] er, input logic [31:0] eh, input logic ed);
    int cyc, nbusy, elat;
    elat = ((op == 4'd7) || (op == 4'd8 && ib != 32'd0)) ? 33 : 1;
    @(negedge clk);
    alu_ctrl = op; a = ia; b = ib; shamt = sh; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; shamt = 5'($urandom);
    cyc = 1; nbusy = 0;
    while (!done && cyc < 40) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " latency"}, 64'(cyc), 64'(elat));
    chk({nm, " busy_cycles"}, 64'(nbusy), 64'(elat - 1));
    chk({nm, " result"}, 64'(result), 64'(er));
    chk({nm, " hi"}, 64'(hi), 64'(eh));
    chk({nm, " div_by_zero"}, 64'(div_by_zero), 64'(ed));
    chk({nm, " zero"}, 64'(zero), 64'(er == 32'd0));
    chk({nm, " busy_with_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] er, eh, ra, rb;
    logic        ed, seen;
    logic [3:0]  rop;
    logic [4:0]  rsh;
    int          cyc;

    tbl[0]  = '{4'd0,  32'hF0F0_1234, 32'h0FF0_FF00, 5'd0,  32'h00F0_1200, 32'd0, 1'b0};
    tbl[1]  = '{4'd1,  32'hF0F0_1234, 32'h0FF0_FF00, 5'd0,  32'hFFF0_FF34, 32'd0, 1'b0};
    tbl[2]  = '{4'd2,  32'd5,         32'd7,         5'd0,  32'd12,        32'd0, 1'b0};
    tbl[3]  = '{4'd2,  32'hFFFF_FFFF, 32'd1,         5'd0,  32'd0,         32'd0, 1'b0};
    tbl[4]  = '{4'd3,  32'd9,         32'd9,         5'd0,  32'd0,         32'd0, 1'b0};
    tbl[5]  = '{4'd3,  32'd0,         32'd1,         5'd0,  32'hFFFF_FFFF, 32'd0, 1'b0};
    tbl[6]  = '{4'd4,  32'hFFFF_FFFF, 32'd1,         5'd0,  32'd1,         32'd0, 1'b0};
    tbl[7]  = '{4'd4,  32'd1,         32'hFFFF_FFFF, 5'd0,  32'd0,         32'd0, 1'b0};
    tbl[8]  = '{4'd5,  32'd1,         32'hFFFF_FFFF, 5'd0,  32'd1,         32'd0, 1'b0};
    tbl[9]  = '{4'd6,  32'h0000_FFFF, 32'd0,         5'd0,  32'hFFFF_0000, 32'd0, 1'b0};
    tbl[10] = '{4'd9,  32'd1,         32'd0,         5'd31, 32'h8000_0000, 32'd0, 1'b0};
    tbl[11] = '{4'd10, 32'h8000_0000, 32'd0,         5'd31, 32'd1,         32'd0, 1'b0};
    tbl[12] = '{4'd11, 32'd3,         32'd3,         5'd0,  32'd1,         32'd0, 1'b0};
    tbl[13] = '{4'd12, 32'h8000_0000, 32'd0,         5'd0,  32'd0,         32'd0, 1'b0};
    tbl[14] = '{4'd13, 32'd42,        32'd42,        5'd0,  32'd1,         32'd0, 1'b0};
    tbl[15] = '{4'd14, 32'd42,        32'd42,        5'd0,  32'd0,         32'd0, 1'b0};
    tbl[16] = '{4'd15, 32'd5,         32'd7,         5'd0,  32'd0,         32'd0, 1'b0};
    tbl[17] = '{4'd7,  32'd7,         32'd6,         5'd0,  32'd42,        32'd0, 1'b0};
    tbl[18] = '{4'd8,  32'd100,       32'd7,         5'd0,  32'd14,        32'd2, 1'b0};
    tbl[19] = '{4'd8,  32'd100,       32'd0,         5'd0,  32'hFFFF_FFFF, 32'd100, 1'b1};
`ifdef ALU_SIGNED_MULDIV_EN
    tbl[20] = '{4'd7,  32'hFFFF_FFFD, 32'd5,         5'd0,  32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0};
    tbl[21] = '{4'd8,  32'hFFFF_FFF9, 32'd2,         5'd0,  32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    tbl[22] = '{4'd7,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'd1,         32'd0, 1'b0};
`else
    tbl[20] = '{4'd7,  32'hFFFF_FFFD, 32'd5,         5'd0,  32'hFFFF_FFF1, 32'd4, 1'b0};
    tbl[21] = '{4'd8,  32'hFFFF_FFF9, 32'd2,         5'd0,  32'h7FFF_FFFC, 32'd1, 1'b0};
    tbl[22] = '{4'd7,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'd1,         32'hFFFF_FFFE, 1'b0};
`endif

    rst = 1'b1; start = 1'b0; alu_ctrl = '0; a = '0; b = '0; shamt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset result", 64'(result), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset div_by_zero", 64'(div_by_zero), 64'd0);
    chk("reset zero", 64'(zero), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++)
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh,
            tbl[i].r, tbl[i].h, tbl[i].d);

    // result holds and done drops once the pipeline goes idle
    repeat (3) @(posedge clk);
    #1;
    chk("hold done_low", 64'(done), 64'd0);
    chk("hold result", 64'(result), 64'(tbl[NVEC-1].r));

    // start while a multiply is iterating must be ignored
    @(negedge clk);
    alu_ctrl = 4'd7; a = 32'd7; b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1;
    repeat (4) begin @(posedge clk); #1; cyc++; end
    @(negedge clk);
    alu_ctrl = 4'd2; a = 32'd1; b = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cyc++;
    while (!done && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk("midop latency", 64'(cyc), 64'd33);
    chk("midop result", 64'(result), 64'd42);
    chk("midop hi", 64'(hi), 64'd0);

    // reset part-way through a multiply: abort, clear outputs, no done
    do_op("pre_abort", 4'd8, 32'd55, 32'd0, 5'd0, 32'hFFFF_FFFF, 32'd55, 1'b1);
    @(negedge clk);
    alu_ctrl = 4'd7; a = 32'hFFFF_FFFF; b = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort result", 64'(result), 64'd0);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort div_by_zero", 64'(div_by_zero), 64'd0);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
    chk("abort no_activity", 64'(seen), 64'd0);
    do_op("post_abort add", 4'd2, 32'd5, 32'd7, 5'd0, 32'd12, 32'd0, 1'b0);

    // reset and start in the same cycle: request is dropped
    @(negedge clk);
    rst = 1'b1; start = 1'b1; alu_ctrl = 4'd2; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
    chk("rst_start dropped", 64'(seen), 64'd0);
    chk("rst_start result", 64'(result), 64'd0);

    // random ops, issued back-to-back so many are accepted straight from DONE
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 :
            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 5) == 0) rb = ra;
      rsh = 5'($urandom);
      model(rop, ra, rb, rsh, er, eh, ed);
      do_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, rsh, er, eh, ed);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
